uart_tx_scheduler: RTL

Round-robin transmit scheduler that shares one UART serial line between `NUM_REQ` byte-stream requesters. It arbitrates among pending requests, accepts one word per frame over a valid/ready handshake, and serializes it LSB-first with start, optional parity and stop bits. Bit timing comes from the `baud_tick` output of the UART baud generator, so the block sits between client logic and the physical `tx` pin.

---
 rtl/uart_tx_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin UART transmit scheduler: arbitrates NUM_REQ word requesters onto one
// serial line, framing each word as start / LSB-first data / optional even parity / stop.
module uart_tx_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1,
    localparam int GW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         baud_tick,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx,
    output logic                         busy,
    output logic [GW-1:0]                grant_id,
    output logic                         frame_done
);

    localparam int       IW        = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic     STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, ARMED, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_nx;
    logic [GW-1:0]          last_grant, win;
    logic                   any_valid, accept, final_tick, data_last;
    logic [DATA_BITS-1:0]   win_data, shreg;
    logic                   par;
    logic [IW-1:0]          bit_idx;
    logic                   stop_cnt;
    int                     cand;

    // Round-robin search from last_grant+1; walking downward lets the nearest index win.
    always_comb begin
        win  = '0;
        cand = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (req_valid[cand]) win = GW'(cand);
        end
        any_valid = |req_valid;
        win_data  = req_data[int'(win)*DATA_BITS +: DATA_BITS];
    end

    assign final_tick = (state == STOP) && baud_tick && (stop_cnt == STOP_LAST);
    assign data_last  = (bit_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_valid) state_nx = ARMED;
            ARMED:   if (baud_tick) state_nx = START;
            START:   if (baud_tick) state_nx = DATA;
            DATA:    if (baud_tick && data_last) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (baud_tick) state_nx = STOP;
            STOP:    if (final_tick) state_nx = any_valid ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Accept happens either from IDLE or on the final stop tick (back-to-back frames).
    always_comb begin
        accept    = !rst && any_valid && ((state == IDLE) || final_tick);
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx         <= 1'b1;
            shreg      <= '0;
            par        <= 1'b0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            grant_id   <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            frame_done <= 1'b0;
        end else begin
            frame_done <= final_tick;
            if (accept) begin
                shreg      <= win_data;
                par        <= ^win_data;
                grant_id   <= win;
                last_grant <= win;
            end
            if (baud_tick) begin
                case (state)
                    ARMED: tx <= 1'b0;
                    START: begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                    DATA: begin
                        if (!data_last) begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end else begin
                            tx       <= (PARITY_EN != 0) ? par : 1'b1;
                            stop_cnt <= 1'b0;
                        end
                    end
                    PARITY: begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                    STOP: begin
                        if (stop_cnt == STOP_LAST) tx <= !any_valid;
                        else                       stop_cnt <= stop_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
